// File: rtl/wb_core_debug_ctrl.sv
// Wishbone debug/control slave for one user-area microcontroller core.
// Forces pad inputs, holds reset, free-runs/multi-steps/halts on PC breakpoint.
module wb_core_debug_ctrl #(
   parameter int K_WIDTH    = 4,
   parameter int OUT_WIDTH  = 24,
   parameter int ADDR_WIDTH = 11,
   parameter int STEP_WIDTH = 16,
   parameter int ACK_DELAY  = 2
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic [31:0]           wbs_dat_o,
   input  logic                  wbs_we_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   output logic                  wbs_ack_o,
   input  logic [K_WIDTH-1:0]    pin_k_i,
   input  logic                  pin_cs_i,
   input  logic [ADDR_WIDTH-1:0] core_pc_i,
   input  logic [OUT_WIDTH-1:0]  core_out_i,
   input  logic                  core_status_i,
   output logic [K_WIDTH-1:0]    core_k_o,
   output logic                  core_cs_o,
   output logic                  core_reset_o,
   output logic                  core_step_o,
   output logic                  irq_o
);

   localparam int DW = $clog2(ACK_DELAY + 1);

   typedef enum logic [1:0] {
      S_FREE = 2'd0,
      S_IDLE = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic                  override_q, hold_q, cs_ovr_q;
   logic                  ie_bp_q, ie_step_q;
   logic [K_WIDTH-1:0]    k_ovr_q;
   logic [STEP_WIDTH-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0] bp_addr_q;
   logic                  bp_en_q;
   logic                  bp_hit_q, step_done_q;
   logic                  pend_q;
   logic [DW-1:0]         dly_q;
   logic                  set_bp, set_done;

   logic [2:0]            idx;
   logic                  acc, wr, busy, bp_match;
   logic                  wr_ctrl, wr_step, wr_bp, wr_stat;
   logic [STEP_WIDTH-1:0] step_val;
   logic                  step_load, w1c_bp, w1c_done;
   logic [31:0]           rdata;
   logic                  unused;

   assign unused = ^{wbs_adr_i, wbs_dat_i};

   assign idx      = wbs_adr_i[4:2];
   assign acc      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~pend_q;
   assign wr       = acc & wbs_we_i;
   assign wr_ctrl  = wr & (idx == 3'd0);
   assign wr_step  = wr & (idx == 3'd1);
   assign wr_bp    = wr & (idx == 3'd2);
   assign wr_stat  = wr & (idx == 3'd3);
   assign step_val = wbs_dat_i[STEP_WIDTH-1:0];
   assign step_load = wr_step & (step_val != '0);
   assign w1c_bp   = wr_stat & wbs_dat_i[1];
   assign w1c_done = wr_stat & wbs_dat_i[2];
   assign busy     = (state_q == S_STEP);

   assign core_k_o     = override_q ? k_ovr_q : pin_k_i;
   assign core_cs_o    = override_q ? cs_ovr_q : pin_cs_i;
   assign core_reset_o = ~wb_rst_i | hold_q;
   assign core_step_o  = ((state_q == S_FREE) | (state_q == S_STEP))
                         & wb_rst_i;

   // the hitting cycle is still a stepped cycle
   assign bp_match = bp_en_q & (core_pc_i == bp_addr_q) & core_step_o;

   // register read mux, sampled at acceptance
   always_comb begin
      rdata = '0;
      case (idx)
         3'd0: begin
            rdata[4:0] = {ie_step_q, ie_bp_q, cs_ovr_q, hold_q, override_q};
            rdata[8 +: K_WIDTH] = k_ovr_q;
         end
         3'd1: rdata[STEP_WIDTH-1:0] = count_q;
         3'd2: begin
            rdata[ADDR_WIDTH-1:0] = bp_addr_q;
            rdata[31] = bp_en_q;
         end
         3'd3: rdata[7:0] = {2'b00, state_q, core_status_i,
                             step_done_q, bp_hit_q, busy};
         3'd4: rdata[OUT_WIDTH-1:0] = core_out_i;
         3'd5: rdata[ADDR_WIDTH-1:0] = core_pc_i;
         default: rdata = '0;
      endcase
   end

   // run-control next state; breakpoint beats step completion
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      set_bp   = 1'b0;
      set_done = 1'b0;
      case (state_q)
         S_FREE: begin
            if (bp_match) begin
               state_d = S_HALT;
               set_bp  = 1'b1;
            end else if (override_q) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!override_q) begin
               state_d = S_FREE;
            end else if (step_load) begin
               state_d = S_STEP;
               count_d = step_val;
            end
         end
         S_STEP: begin
            if (bp_match) begin
               state_d = S_HALT;
               count_d = '0;
               set_bp  = 1'b1;
            end else if (!override_q) begin
               state_d = S_FREE;
               count_d = '0;
            end else if (count_q <= STEP_WIDTH'(1)) begin
               state_d  = S_IDLE;
               count_d  = '0;
               set_done = 1'b1;
            end else begin
               count_d = count_q - STEP_WIDTH'(1);
            end
         end
         S_HALT: begin
            if (!bp_hit_q) state_d = override_q ? S_IDLE : S_FREE;
         end
         default: state_d = S_FREE;
      endcase
   end

   // bus handshake: delayed ack pulse, cancelled if cyc drops
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         pend_q    <= 1'b0;
         dly_q     <= '0;
      end else begin
         wbs_ack_o <= 1'b0;
         if (acc) begin
            if (ACK_DELAY <= 1) begin
               wbs_ack_o <= 1'b1;
            end else begin
               pend_q <= 1'b1;
               dly_q  <= DW'(ACK_DELAY - 1);
            end
            if (!wbs_we_i) wbs_dat_o <= rdata;
         end else if (pend_q) begin
            if (!wbs_cyc_i) begin
               pend_q <= 1'b0;
            end else if (dly_q == DW'(1)) begin
               wbs_ack_o <= 1'b1;
               pend_q    <= 1'b0;
            end else begin
               dly_q <= dly_q - DW'(1);
            end
         end
      end
   end

   // control and breakpoint registers, committed at acceptance
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         override_q <= 1'b0;
         hold_q     <= 1'b0;
         cs_ovr_q   <= 1'b0;
         ie_bp_q    <= 1'b0;
         ie_step_q  <= 1'b0;
         k_ovr_q    <= '0;
         bp_addr_q  <= '0;
         bp_en_q    <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            override_q <= wbs_dat_i[0];
            hold_q     <= wbs_dat_i[1];
            cs_ovr_q   <= wbs_dat_i[2];
            ie_bp_q    <= wbs_dat_i[3];
            ie_step_q  <= wbs_dat_i[4];
            k_ovr_q    <= wbs_dat_i[8 +: K_WIDTH];
         end
         if (wr_bp) begin
            bp_addr_q <= wbs_dat_i[ADDR_WIDTH-1:0];
            bp_en_q   <= wbs_dat_i[31];
         end
      end
   end

   // run-control state and step counter
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q <= S_FREE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // sticky event flags (a new hit beats a clear) and registered irq
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         bp_hit_q    <= 1'b0;
         step_done_q <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         bp_hit_q    <= set_bp | (bp_hit_q & ~w1c_bp);
         step_done_q <= set_done | (step_done_q & ~w1c_done);
         irq_o       <= (bp_hit_q & ie_bp_q) | (step_done_q & ie_step_q);
      end
   end

endmodule

// File: tb/tb_wb_core_debug_ctrl.sv
// Bench for wb_core_debug_ctrl: directed bus vectors, read data
// checked by a scoreboard monitor on every ack.
module tb_wb_core_debug_ctrl;
   localparam int KW = 4;
   localparam int OW = 24;
   localparam int AW = 11;
   localparam int SW = 16;
   localparam int AD = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   adr, dat_w, dat_r;
   logic          we, cyc, stb, ack;
   logic [KW-1:0] pin_k, core_k;
   logic          pin_cs, core_cs;
   logic [AW-1:0] pc;
   logic [OW-1:0] cout;
   logic          cstat, creset, cstep, irq;

   always #5 clk = ~clk;

   wb_core_debug_ctrl #(
      .K_WIDTH(KW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW),
      .STEP_WIDTH(SW), .ACK_DELAY(AD)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(dat_r),
      .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
      .wbs_ack_o(ack),
      .pin_k_i(pin_k), .pin_cs_i(pin_cs),
      .core_pc_i(pc), .core_out_i(cout), .core_status_i(cstat),
      .core_k_o(core_k), .core_cs_o(core_cs),
      .core_reset_o(creset), .core_step_o(cstep), .irq_o(irq)
   );

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   vecs = 0;
   int   errs = 0;
   int   nstep = 0;
   logic run_pc = 1'b0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every ack pops one expected entry
   always @(negedge clk) begin
      exp_t e;
      if (ack) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_ack: got 1 want 0");
         end else begin
            e = sb.pop_front();
            if (e.chk) check(e.name, dat_r, e.exp);
         end
      end
   end

   // step pulse counter; optionally models a PC advancing per step
   always @(negedge clk) begin
      if (cstep) begin
         nstep++;
         if (run_pc) pc = 11'h11F + 11'(nstep);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic bus(input logic w, input logic [2:0] idx,
                      input logic [31:0] d, input logic [31:0] ex,
                      input string nm);
      exp_t e;
      int   n;
      bit   got;
      e.chk  = !w;
      e.exp  = ex;
      e.name = nm;
      sb.push_back(e);
      @(negedge clk);
      adr = {27'd0, idx, 2'b00};
      dat_w = d;
      we = w;
      cyc = 1'b1;
      stb = 1'b1;
      @(posedge clk);
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (ack) got = 1;
      end
      cyc = 1'b0;
      stb = 1'b0;
      we = 1'b0;
      if (!got) begin
         e = sb.pop_back();
         vecs++;
         errs++;
         $display("FAIL %s_noack: got none want ack", nm);
      end else begin
         check({nm, "_lat"}, 32'(n), 32'(AD));
      end
   endtask

   task automatic rd(input logic [2:0] idx, input logic [31:0] ex,
                     input string nm);
      bus(1'b0, idx, 32'd0, ex, nm);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      bus(1'b1, idx, d, 32'd0, "wr");
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit got;
      rst = 1'b0;
      adr = '0;
      dat_w = '0;
      we = 1'b0;
      cyc = 1'b0;
      stb = 1'b0;
      pin_k = 4'hA;
      pin_cs = 1'b1;
      pc = 11'h050;
      cout = 24'hABCDEF;
      cstat = 1'b0;

      wait_n(3);
      check("rst_ack", ack, 0);
      check("rst_dat", dat_r, 0);
      check("rst_irq", irq, 0);
      check("rst_step", cstep, 0);
      check("rst_creset", creset, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rel_step", cstep, 1);
      check("rel_creset", creset, 0);

      rd(3'd0, 32'h0, "ctrl_rst");
      rd(3'd3, 32'h0, "status_rst");
      rd(3'd4, 32'h00AB_CDEF, "out");
      rd(3'd5, 32'h050, "pc");
      rd(3'd6, 32'h0, "idx6");
      check("k_pass", core_k, 4'hA);
      check("cs_pass", core_cs, 1);
      wr(3'd1, 32'd5);
      rd(3'd1, 32'h0, "step_in_free");
      rd(3'd3, 32'h0, "status_free");

      wr(3'd0, 32'h0501);
      wait_n(2);
      check("k_ovr", core_k, 4'h5);
      check("cs_ovr", core_cs, 0);
      check("idle_step", cstep, 0);
      rd(3'd0, 32'h0501, "ctrl");
      rd(3'd3, 32'h10, "status_idle");
      nstep = 0;
      wr(3'd1, 32'd3);
      wait_n(8);
      check("step3_pulses", 32'(nstep), 3);
      rd(3'd3, 32'h14, "status_done");
      rd(3'd1, 32'h0, "step_cnt0");
      wr(3'd3, 32'h4);
      rd(3'd3, 32'h10, "status_w1c");

      wr(3'd0, 32'h0008);
      wait_n(2);
      rd(3'd3, 32'h0, "status_free2");
      wr(3'd2, 32'h8000_0123);
      rd(3'd2, 32'h8000_0123, "bp");
      @(negedge clk);
      pc = 11'h123;
      @(negedge clk);
      check("halt_step", cstep, 0);
      check("irq_lag", irq, 0);
      @(negedge clk);
      check("irq_bp", irq, 1);
      pc = 11'h050;
      rd(3'd3, 32'h32, "status_halt");
      wr(3'd3, 32'h2);
      wait_n(2);
      rd(3'd3, 32'h0, "status_resume");
      check("irq_clr", irq, 0);
      check("free_step", cstep, 1);

      wr(3'd0, 32'h0001);
      wait_n(2);
      rd(3'd3, 32'h10, "status_idle2");
      nstep = 0;
      run_pc = 1'b1;
      wr(3'd1, 32'd10);
      wait_n(12);
      check("bp_step_pulses", 32'(nstep), 4);
      run_pc = 1'b0;
      pc = 11'h050;
      rd(3'd3, 32'h32, "status_bp_step");
      rd(3'd1, 32'h0, "step_bp_cnt");
      wr(3'd3, 32'h2);
      wait_n(2);
      rd(3'd3, 32'h10, "status_idle3");

      wr(3'd1, 32'd10);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_ack", ack, 0);
      check("mid_dat", dat_r, 0);
      check("mid_irq", irq, 0);
      check("mid_step", cstep, 0);
      check("mid_creset", creset, 1);
      check("mid_k", core_k, 4'hA);
      @(negedge clk);
      rst = 1'b1;
      rd(3'd3, 32'h0, "status_rst2");
      rd(3'd0, 32'h0, "ctrl_rst2");
      rd(3'd2, 32'h0, "bp_rst2");
      rd(3'd1, 32'h0, "step_rst2");

      @(negedge clk);
      adr = 32'h0;
      dat_w = 32'h3;
      we = 1'b1;
      cyc = 1'b1;
      stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0;
      stb = 1'b0;
      we = 1'b0;
      got = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack) got = 1;
      end
      check("ack_cancel", 32'(got), 0);
      rd(3'd0, 32'h3, "ctrl_cancel");
      check("hold_creset", creset, 1);
      check("k_ovr0", core_k, 4'h0);
      check("cs_ovr0", core_cs, 0);
      cstat = 1'b1;
      cout = 24'h123456;
      wait_n(2);
      rd(3'd3, 32'h18, "status_hold");
      rd(3'd4, 32'h0012_3456, "out2");
      wait_n(2);
      check("sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/wb_core_debug_ctrl.md
Name: wb_core_debug_ctrl

Overview:
Parametrised Wishbone debug/control slave for the user-area microcontroller cores. It sits between the Caravel Wishbone bus and one core instance.
- Can force the core's pad inputs (K, chip select) and can hold the core in reset.
- Supports free-run, N-cycle multi-step, and program-counter breakpoint halt.
- Captures core outputs and PC for readback and raises an interrupt on halt or step completion.
- Unlike the single-step override of the previous generation, it generalises K/output/address widths and ack latency.

Parameters:
K_WIDTH, 4, width of K input bus
OUT_WIDTH, 24, width of core output snapshot (O+R lines); must be ≤ 32
ADDR_WIDTH, 11, width of core PC / ROM byte address
STEP_WIDTH, 16, width of step counter
ACK_DELAY, 2, cycles from transaction acceptance to ack pulse; must be ≥ 1

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-low reset
wbs_adr_i  in  32  byte address; bits [4:2] select register
wbs_dat_i  in  32  write data
wbs_dat_o  out  32  read data
wbs_we_i  in  1  write enable
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_ack_o  out  1  acknowledge
pin_k_i  in  K_WIDTH  K from pads
pin_cs_i  in  1  chip select from pads
core_pc_i  in  ADDR_WIDTH  core program counter
core_out_i  in  OUT_WIDTH  core O/R outputs
core_status_i  in  1  core status flag
core_k_o  out  K_WIDTH  K to core
core_cs_o  out  1  chip select to core
core_reset_o  out  1  active-high core reset
core_step_o  out  1  core clock-enable
irq_o  out  1  interrupt request

Behaviour:
Register map, word index = adr[4:2]:
- 0 CTRL (rw): [0] override, [1] hold_reset, [2] cs_ovr, [3] ie_bp, [4] ie_step, [8+:K_WIDTH] k_ovr.
- 1 STEP (w): load count. Read returns remaining count.
- 2 BP (rw): [ADDR_WIDTH-1:0] bp_addr, [31] bp_en.
- 3 STATUS: bit0 busy (ro), bit1 bp_hit (W1C), bit2 step_done (W1C), bit3 core_status_i (ro), bits[7:4] state code (ro).
- 4 OUT (ro): core_out_i zero-extended, captured at acceptance.
- 5 PC (ro): core_pc_i zero-extended.
- 6, 7: read 0, writes ignored.

Reset (wb_rst_i=0 at a clock edge):
- All registers 0, state FREE.
- wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- core_step_o=0 while wb_rst_i low.

Wishbone:
- Acceptance: the cycle where cyc&stb is high, ack is low and no transaction is pending.
- Writes commit at acceptance. Read data is latched into wbs_dat_o at acceptance and held until ack.
- wbs_ack_o is a single-cycle pulse exactly ACK_DELAY cycles after acceptance.
- If cyc drops before the ack, the ack is cancelled; an already-committed write stays committed.

Combinational outputs:
- core_k_o = override ? k_ovr : pin_k_i.
- core_cs_o = override ? cs_ovr : pin_cs_i.
- core_reset_o = ~wb_rst_i | hold_reset.
- core_step_o = (state==FREE | state==STEP) & wb_rst_i.
- irq_o = registered (bp_hit&ie_bp)|(step_done&ie_step), so it lags its sources by 1 cycle.

State machine (FREE, IDLE, STEP, HALT):
- FREE→IDLE when override becomes 1.
- IDLE→FREE when override becomes 0.
- IDLE→STEP on a write to STEP with value ≠ 0; count is loaded.
- STEP: count decrements each cycle. When it goes 1→0: step_done set, STEP→IDLE, so exactly N core_step_o cycles are issued.
- STEP→FREE if override is cleared; count is zeroed.
- Breakpoint: in FREE or STEP, if bp_en & core_pc_i==bp_addr & core_step_o in a cycle → bp_hit set, count zeroed, next state HALT. The hitting cycle is itself stepped.
- HALT→(override ? IDLE : FREE) on the cycle after bp_hit is cleared by W1C.
- Breakpoint wins over a simultaneous step completion; step_done is not set.
- A STEP write in FREE, HALT or STEP is ignored. A STEP write of 0 is ignored.
- A W1C and a new hit in the same cycle: the hit wins and the bit stays 1.
- hold_reset does not alter state.

Test Plan:
- Reset, then read CTRL/STATUS → 0x0/0x0 (state FREE); core_step_o=1 from first cycle after reset release; ack arrives exactly 2 cycles after acceptance.
- CTRL=0x0501 (override, k_ovr=5), then STEP=3 → core_k_o=5; core_step_o high exactly 3 cycles; STATUS bit2=1; state IDLE.
- BP=0x8000_0123 in FREE; drive core_pc_i=0x123 → STATUS bp_hit=1, state HALT, core_step_o=0 next cycle; with ie_bp set, irq_o=1 one cycle later. Write STATUS=0x2 → back to FREE.
- STEP=10 while BP hits on the 4th step cycle → 4 step pulses, HALT, step_done=0, STEP readback=0.
- Assert wb_rst_i=0 mid-STEP (count 7) → next edge: all registers 0, FREE, ack=0, core_reset_o=1 while low.
- Drop cyc one cycle after acceptance of a CTRL write of 0x3 → no ack; CTRL reads 0x3; core_reset_o=1.
